// File: rtl/score4_move_ctrl.sv
// Move controller for a four-in-a-row game panel: cursor handling, token drops,
// handshake with an external win checker and sticky game-result flags.
module score4_move_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic [2:0] cursor_col,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic       wr_player,
  output logic       chk_start,
  output logic       player,
  output logic       invalid_move,
  output logic       win_a,
  output logic       win_b,
  output logic       full_panel
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int TW = $clog2(ROWS * COLS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_CHECK = 3'd2,
    S_NEXT  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_left_d;
  logic            r_right_d;
  logic            r_put_d;
  logic [HW-1:0]   r_height [COLS];
  logic [TW-1:0]   r_total;
  logic [2:0]      r_cursor;
  logic            r_wr_en;
  logic [2:0]      r_wr_row;
  logic [2:0]      r_wr_col;
  logic            r_wr_player;
  logic            r_chk_start;
  logic            r_player;
  logic            r_invalid;
  logic            r_win_a;
  logic            r_win_b;
  logic            r_full;

  logic w_left_e;
  logic w_right_e;
  logic w_put_e;
  logic w_multi;
  logic w_col_full;

  assign w_left_e   = left  & ~r_left_d;
  assign w_right_e  = right & ~r_right_d;
  assign w_put_e    = put   & ~r_put_d;
  assign w_multi    = (w_left_e & w_right_e) | (w_left_e & w_put_e) | (w_right_e & w_put_e);
  assign w_col_full = (r_height[r_cursor] == HW'(ROWS));

  // Previous-cycle copies of the buttons for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left_d  <= 1'b0;
      r_right_d <= 1'b0;
      r_put_d   <= 1'b0;
    end else begin
      r_left_d  <= left;
      r_right_d <= right;
      r_put_d   <= put;
    end
  end

  // Game FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_total     <= '0;
      r_cursor    <= 3'd0;
      r_wr_en     <= 1'b0;
      r_wr_row    <= 3'd0;
      r_wr_col    <= 3'd0;
      r_wr_player <= 1'b0;
      r_chk_start <= 1'b0;
      r_player    <= 1'b0;
      r_invalid   <= 1'b0;
      r_win_a     <= 1'b0;
      r_win_b     <= 1'b0;
      r_full      <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        r_height[c] <= '0;
      end
    end else begin
      r_wr_en     <= 1'b0;
      r_chk_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_multi) begin
            r_invalid <= 1'b1;
          end else if (w_left_e) begin
            if (r_cursor == 3'd0) begin
              r_invalid <= 1'b1;
            end else begin
              r_cursor  <= r_cursor - 3'd1;
              r_invalid <= 1'b0;
            end
          end else if (w_right_e) begin
            if (r_cursor == 3'(COLS - 1)) begin
              r_invalid <= 1'b1;
            end else begin
              r_cursor  <= r_cursor + 3'd1;
              r_invalid <= 1'b0;
            end
          end else if (w_put_e) begin
            if (w_col_full) begin
              r_invalid <= 1'b1;
            end else begin
              // Write strobe is raised together with the WRITE state
              r_invalid   <= 1'b0;
              r_wr_en     <= 1'b1;
              r_wr_row    <= 3'(r_height[r_cursor]);
              r_wr_col    <= r_cursor;
              r_wr_player <= r_player;
              r_state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_height[r_wr_col] <= r_height[r_wr_col] + HW'(1);
          r_total            <= r_total + TW'(1);
          r_chk_start        <= 1'b1;
          r_state            <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_done) begin
            if (chk_win) begin
              if (r_player) begin
                r_win_b <= 1'b1;
              end else begin
                r_win_a <= 1'b1;
              end
              r_state <= S_OVER;
            end else if (r_total == TW'(ROWS * COLS)) begin
              r_full  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          r_player <= ~r_player;
          r_state  <= S_IDLE;
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cursor_col   = r_cursor;
  assign wr_en        = r_wr_en;
  assign wr_row       = r_wr_row;
  assign wr_col       = r_wr_col;
  assign wr_player    = r_wr_player;
  assign chk_start    = r_chk_start;
  assign player       = r_player;
  assign invalid_move = r_invalid;
  assign win_a        = r_win_a;
  assign win_b        = r_win_b;
  assign full_panel   = r_full;

endmodule

// File: tb/tb_score4_move_ctrl.sv
// Bench for score4_move_ctrl: directed scenarios plus random play against a
// game-level reference model (cursor, column heights, turn, result).
module tb_score4_move_ctrl;
  localparam int COLS = 7;
  localparam int ROWS = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic left = 1'b0, right = 1'b0, put = 1'b0, chk_done = 1'b0, chk_win = 1'b0;
  logic [2:0] cursor_col, wr_row, wr_col;
  logic wr_en, wr_player, chk_start, player, invalid_move, win_a, win_b, full_panel;

  score4_move_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .chk_done(chk_done), .chk_win(chk_win), .cursor_col(cursor_col),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player),
    .chk_start(chk_start), .player(player), .invalid_move(invalid_move),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cnt_wr = 0;
  int cnt_cs = 0;
  logic [2:0] last_row, last_col;
  logic last_pl;

  // Reference model of the game: res 0 = playing, 1 = A won, 2 = B won, 3 = full
  int m_cursor, m_player, m_invalid, m_res, m_total;
  int m_height [COLS];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cnt_wr++;
      last_row = wr_row;
      last_col = wr_col;
      last_pl  = wr_player;
    end
    if (chk_start === 1'b1) cnt_cs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [7:0] exp_state();
    return {m_cursor[2:0], m_player[0], m_invalid[0], m_res == 1, m_res == 2, m_res == 3};
  endfunction

  function automatic void model_reset();
    m_cursor = 0; m_player = 0; m_invalid = 0; m_res = 0; m_total = 0;
    for (int c = 0; c < COLS; c++) m_height[c] = 0;
  endfunction

  function automatic void model_move(input int dir);
    int nxt;
    if (m_res != 0) return;
    nxt = m_cursor + dir;
    if (nxt < 0 || nxt >= COLS) m_invalid = 1;
    else begin
      m_cursor = nxt;
      m_invalid = 0;
    end
  endfunction

  function automatic void model_multi();
    if (m_res == 0) m_invalid = 1;
  endfunction

  function automatic void model_put(input bit win, output bit wrote, output int row);
    wrote = 1'b0;
    row = 0;
    if (m_res != 0) return;
    if (m_height[m_cursor] == ROWS) begin
      m_invalid = 1;
      return;
    end
    wrote = 1'b1;
    row = m_height[m_cursor];
    m_height[m_cursor]++;
    m_total++;
    m_invalid = 0;
    if (win) m_res = (m_player == 1) ? 2 : 1;
    else if (m_total == ROWS * COLS) m_res = 3;
    else m_player = 1 - m_player;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    left = 1'b0; right = 1'b0; put = 1'b0; chk_done = 1'b0; chk_win = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic press(input bit l, input bit r, input bit p);
    left = l; right = r; put = p;
    tick();
    left = 1'b0; right = 1'b0; put = 1'b0;
    tick();
  endtask

  // Drop a token and answer the checker after 'delay' cycles of CHECK
  task automatic put_seq(input bit win, input int delay, output bit wr1, output bit cs2, output bit pl1);
    put = 1'b1;
    tick();
    wr1 = wr_en;
    put = 1'b0;
    tick();
    cs2 = chk_start;
    repeat (delay) tick();
    chk_done = 1'b1;
    chk_win = win;
    tick();
    pl1 = player;
    chk_done = 1'b0;
    chk_win = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    left = 1'b1; put = 1'b1; chk_done = 1'b1; chk_win = 1'b1;
    tick();
    tick();
    if ({cursor_col, wr_en, wr_row, wr_col, wr_player, chk_start, player, invalid_move,
         win_a, win_b, full_panel} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got cursor=%0d wr_en=%b chk_start=%b player=%b inv=%b flags=%b%b%b, want all 0",
               cursor_col, wr_en, chk_start, player, invalid_move, win_a, win_b, full_panel);
    end
    n_chk++;
    do_reset();
  endtask

  task automatic test_cursor();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    model_move(-1);
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL cursor_left_at_0: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    press(1'b0, 1'b1, 1'b0);
    model_move(1);
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL cursor_right_from_0: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    press(1'b1, 1'b1, 1'b0);
    model_multi();
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL cursor_multi_edge: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 1'b1, 1'b0);
      model_move(1);
      if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
        n_err++;
        $display("FAIL cursor_right_sat step %0d: got %b want %b", i, {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
      end
      n_chk++;
    end
  endtask

  task automatic test_hold_through_reset();
    rst = 1'b0;
    right = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    model_move(1);
    repeat (4) tick();
    right = 1'b0;
    tick();
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL hold_through_reset: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
  endtask

  task automatic test_column_fill();
    bit wr1, cs2, pl1, wrote;
    int row, w0, pl_before;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pl_before = m_player;
      w0 = cnt_wr;
      put_seq(1'b0, i, wr1, cs2, pl1);
      model_put(1'b0, wrote, row);
      if ({cnt_wr - w0 == 1, wr1, cs2} !== {wrote, wrote, wrote}) begin
        n_err++;
        $display("FAIL column_fill_strobes put %0d: got writes=%0d wr1=%b cs2=%b want %b", i, cnt_wr - w0, wr1, cs2, wrote);
      end
      n_chk++;
      if (wrote && {last_row, last_col, last_pl} !== {row[2:0], 3'd0, pl_before[0]}) begin
        n_err++;
        $display("FAIL column_fill_wr put %0d: got row=%0d col=%0d pl=%b want row=%0d col=0 pl=%0d", i, last_row, last_col, last_pl, row, pl_before);
      end
      if (wrote) n_chk++;
      if (pl1 !== pl_before[0]) begin
        n_err++;
        $display("FAIL column_fill_toggle_latency put %0d: got %b want %0d", i, pl1, pl_before);
      end
      n_chk++;
      if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
        n_err++;
        $display("FAIL column_fill_state put %0d: got %b want %b", i, {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
      end
      n_chk++;
    end
  endtask

  task automatic test_delayed_check();
    bit wrote;
    int row, w0, c0;
    do_reset();
    press(1'b0, 1'b1, 1'b0);
    model_move(1);
    w0 = cnt_wr;
    c0 = cnt_cs;
    put = 1'b1;
    tick();
    put = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      put   = (i >= 3 && i < 5);
      right = (i >= 8 && i < 10);
      left  = (i >= 12 && i < 14);
      tick();
    end
    put = 1'b0; right = 1'b0; left = 1'b0;
    chk_done = 1'b1;
    tick();
    chk_done = 1'b0;
    tick();
    model_put(1'b0, wrote, row);
    if ({cnt_wr - w0, cnt_cs - c0} !== {32'd1, 32'd1}) begin
      n_err++;
      $display("FAIL delayed_check_pulses: got wr=%0d cs=%0d want 1 and 1", cnt_wr - w0, cnt_cs - c0);
    end
    n_chk++;
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL delayed_check_state: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    chk_done = 1'b1;
    chk_win = 1'b1;
    tick();
    chk_done = 1'b0;
    chk_win = 1'b0;
    tick();
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL stray_chk_done: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
  endtask

  task automatic test_win_b();
    bit wr1, cs2, pl1, wrote;
    int row, w0;
    do_reset();
    put_seq(1'b0, 2, wr1, cs2, pl1);
    model_put(1'b0, wrote, row);
    press(1'b0, 1'b1, 1'b0);
    model_move(1);
    put_seq(1'b1, 1, wr1, cs2, pl1);
    model_put(1'b1, wrote, row);
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL win_b_flags: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    w0 = cnt_wr;
    put_seq(1'b0, 0, wr1, cs2, pl1);
    model_put(1'b0, wrote, row);
    press(1'b1, 1'b0, 1'b0);
    model_move(-1);
    if (cnt_wr - w0 !== 0) begin
      n_err++;
      $display("FAIL win_b_frozen_writes: got %0d writes want 0", cnt_wr - w0);
    end
    n_chk++;
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL win_b_frozen_state: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
  endtask

  task automatic test_full_and_reset();
    bit wr1, cs2, pl1, wrote;
    int row, w0;
    do_reset();
    w0 = cnt_wr;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        put_seq(1'b0, 0, wr1, cs2, pl1);
        model_put(1'b0, wrote, row);
      end
      if (c < COLS - 1) begin
        press(1'b0, 1'b1, 1'b0);
        model_move(1);
      end
    end
    if (cnt_wr - w0 !== ROWS * COLS) begin
      n_err++;
      $display("FAIL full_write_count: got %0d want %0d", cnt_wr - w0, ROWS * COLS);
    end
    n_chk++;
    if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
      n_err++;
      $display("FAIL full_panel_state: got %b want %b", {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
    end
    n_chk++;
    do_reset();
    press(1'b0, 1'b1, 1'b0);
    put = 1'b1;
    tick();
    put = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    if ({cursor_col, wr_en, wr_row, wr_col, wr_player, chk_start, player, invalid_move,
         win_a, win_b, full_panel} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid_check: got cursor=%0d wr_col=%0d chk_start=%b, want all outputs 0", cursor_col, wr_col, chk_start);
    end
    n_chk++;
    do_reset();
  endtask

  task automatic test_random();
    bit wr1, cs2, pl1, wrote, win;
    int row, w0, a, pl_before, col_before;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if (m_res != 0) do_reset();
      a = $urandom_range(0, 5);
      w0 = cnt_wr;
      wrote = 1'b0;
      if (a == 0) begin
        press(1'b1, 1'b0, 1'b0);
        model_move(-1);
      end else if (a == 1) begin
        press(1'b0, 1'b1, 1'b0);
        model_move(1);
      end else if (a == 2) begin
        case ($urandom_range(0, 3))
          0: press(1'b1, 1'b1, 1'b0);
          1: press(1'b0, 1'b1, 1'b1);
          2: press(1'b1, 1'b0, 1'b1);
          default: press(1'b1, 1'b1, 1'b1);
        endcase
        model_multi();
      end else begin
        win = ($urandom_range(0, 19) == 0);
        pl_before = m_player;
        col_before = m_cursor;
        put_seq(win, $urandom_range(0, 4), wr1, cs2, pl1);
        model_put(win, wrote, row);
        if (wrote && {last_row, last_col, last_pl} !== {row[2:0], col_before[2:0], pl_before[0]}) begin
          n_err++;
          $display("FAIL random_wr step %0d: got row=%0d col=%0d pl=%b want row=%0d col=%0d pl=%0d",
                   n, last_row, last_col, last_pl, row, col_before, pl_before);
        end
        if (wrote) n_chk++;
      end
      if (cnt_wr - w0 !== int'(wrote)) begin
        n_err++;
        $display("FAIL random_write_count step %0d: got %0d want %0d", n, cnt_wr - w0, wrote);
      end
      n_chk++;
      if ({cursor_col, player, invalid_move, win_a, win_b, full_panel} !== exp_state()) begin
        n_err++;
        $display("FAIL random_state step %0d: got %b want %b", n, {cursor_col, player, invalid_move, win_a, win_b, full_panel}, exp_state());
      end
      n_chk++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cursor();
    test_hold_through_reset();
    test_column_fill();
    test_delayed_check();
    test_win_b();
    test_full_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/score4_move_ctrl.md
SCORE4_MOVE_CTRL -- requirements
Module: score4_move_ctrl

Interface
REQ-001 Parameter COLS, default 7, number of panel columns (cursor range 0..COLS-1).
REQ-002 Parameter ROWS, default 6, number of panel rows (row 0 = bottom).
REQ-003 clk  input  1  system clock; all state SHALL change on rising edge only.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 left  input  1  level button request: move cursor left.
REQ-006 right  input  1  level button request: move cursor right.
REQ-007 put  input  1  level button request: drop token at cursor column.
REQ-008 chk_done  input  1  one-cycle pulse from win checker: result valid.
REQ-009 chk_win  input  1  sampled with chk_done; 1 = last-written token completes four in a line.
REQ-010 cursor_col  output  3  current cursor column.
REQ-011 wr_en  output  1  one-cycle panel-memory write strobe.
REQ-012 wr_row  output  3  write row, valid with wr_en.
REQ-013 wr_col  output  3  write column, valid with wr_en.
REQ-014 wr_player  output  1  token owner written, valid with wr_en (0 = A, 1 = B).
REQ-015 chk_start  output  1  one-cycle pulse requesting win check of (wr_row, wr_col).
REQ-016 player  output  1  player to move (0 = A, 1 = B).
REQ-017 invalid_move  output  1  level; last requested action was rejected.
REQ-018 win_a, win_b, full_panel  output  1 each  game-result flags, sticky until reset.

Function
REQ-019 Each of left/right/put SHALL be rising-edge detected using one registered copy; only edges are actions, and holding a level SHALL produce exactly one action.
REQ-020 Edges SHALL be accepted only in state IDLE; edges arriving in any other state SHALL be discarded, not queued.
REQ-021 Two or more simultaneous edges in IDLE SHALL perform no action and set invalid_move.
REQ-022 The block SHALL keep one height counter per column (0..ROWS) and a total-token counter (0..ROWS*COLS).
REQ-023 FSM states: IDLE, WRITE, CHECK, NEXT, OVER.
REQ-024 IDLE, left edge: cursor_col>0 -> decrement, clear invalid_move; cursor_col==0 -> no move, set invalid_move.
REQ-025 IDLE, right edge: cursor_col<COLS-1 -> increment, clear invalid_move; cursor_col==COLS-1 -> no move, set invalid_move.
REQ-026 IDLE, put edge: height[cursor_col]==ROWS -> set invalid_move, stay IDLE; else clear invalid_move, go to WRITE.
REQ-027 Cursor SHALL saturate; no wrap-around.
REQ-028 WRITE (1 cycle): wr_en=1, wr_row=height[cursor_col], wr_col=cursor_col, wr_player=player; increment that height and total count; go to CHECK.
REQ-029 Entry into CHECK: chk_start=1 for exactly the first CHECK cycle; wr_row/wr_col/wr_player SHALL hold stable throughout CHECK.
REQ-030 CHECK: wait indefinitely for chk_done; chk_done with chk_win=1 -> set win_a (player 0) or win_b (player 1), go to OVER.
REQ-031 CHECK, chk_done with chk_win=0: total==ROWS*COLS -> set full_panel, go to OVER; else go to NEXT.
REQ-032 NEXT (1 cycle): toggle player, return to IDLE.
REQ-033 Latency: put edge registered -> wr_en 1 cycle later -> chk_start next cycle; player toggles 2 cycles after chk_done.
REQ-034 OVER: all inputs ignored; outputs frozen; only reset exits.
REQ-035 chk_done outside CHECK SHALL be ignored.
REQ-036 At most one of win_a/win_b/full_panel SHALL ever be set.

Reset
REQ-037 rst low SHALL immediately force IDLE, cursor_col=0, player=0, all heights=0, total=0, and every output low, in any state including mid-CHECK.
REQ-038 Edge-detect registers SHALL reset to 0, so a button held through reset release produces one action on the first clock.

Verification
REQ-039 Reset, left pulse -> invalid_move=1, cursor_col=0; then right pulse -> cursor_col=1, invalid_move=0.
REQ-040 Seven right pulses from column 0 -> cursor_col=6 after six, seventh sets invalid_move, cursor_col stays 6.
REQ-041 Seven puts in column 0 with chk_win=0 -> wr_row 0..5, player alternates; seventh: no wr_en, invalid_move=1, player unchanged.
REQ-042 Put with chk_done delayed 20 cycles, and extra put/right edges during CHECK -> single wr_en, single chk_start, edges dropped.
REQ-043 chk_win=1 on player B's move -> win_b=1, win_a=0, later puts produce no wr_en.
REQ-044 Fill all 42 cells with chk_win=0 -> full_panel=1 on 42nd chk_done; rst low mid-CHECK -> all outputs 0 at once.
